// File: rtl/snake_defs_pkg.sv
// Shared definitions for the snake display path: cell encodings, grid geometry
// and the RGB565 palette.
package snake_defs;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BODY  = 2'd1,
      CELL_HEAD  = 2'd2,
      CELL_FOOD  = 2'd3
   } cell_t;

   localparam int unsigned GRID_W    = 30;
   localparam int unsigned GRID_H    = 17;
   localparam int unsigned CELL_LOG2 = 4;

   localparam logic [4:0] GRID_W5 = 5'(GRID_W);
   localparam logic [4:0] GRID_H5 = 5'(GRID_H);

   localparam logic [15:0] COL_EMPTY = 16'h0000;
   localparam logic [15:0] COL_BODY  = 16'h07E0;
   localparam logic [15:0] COL_HEAD  = 16'hFFE0;
   localparam logic [15:0] COL_FOOD  = 16'hF800;
   localparam logic [15:0] COL_GRID  = 16'h2104;

   function automatic logic in_grid(input logic [4:0] row, input logic [4:0] col);
      return (col < GRID_W5) && (row < GRID_H5);
   endfunction

endpackage

// File: rtl/snake_grid_ram.sv
// 1024x2 cell store, addressed {row, col}: one write port and two synchronous
// read ports (pixel side and game side), both read-before-write.
module snake_grid_ram
   import snake_defs::*;
(
   input  logic       clk_disp,
   input  logic       rst,
   input  logic       we,
   input  logic [9:0] wr_addr,
   input  logic [1:0] wr_data,
   input  logic [9:0] pix_addr,
   output logic [1:0] pix_data,
   input  logic [9:0] game_addr,
   input  logic       game_in_grid,
   output logic [1:0] game_data
);

   logic [1:0] mem [1024];
   logic [1:0] game_raw;
   logic       game_ok;

   // NOTE: the array and its read registers have no reset so the tools can map
   // them onto RAM; only the small qualifier flop below is reset.
   always_ff @(posedge clk_disp) begin
      if (we) mem[wr_addr] <= wr_data;
      pix_data <= mem[pix_addr];
      game_raw <= mem[game_addr];
   end

   always_ff @(posedge clk_disp or negedge rst) begin
      if (!rst) game_ok <= 1'b0;
      else      game_ok <= game_in_grid;
   end

   assign game_data = game_ok ? game_raw : 2'd0;

endmodule

// File: rtl/snake_pixel_render.sv
// Turns timing-generator coordinates into RGB565 pixels from the game grid,
// two cycles from inputs to rgb/sync, plus a once-per-frame step pulse.
module snake_pixel_render
   import snake_defs::*;
#(
   parameter logic [15:0] P_COL_EMPTY = COL_EMPTY,
   parameter logic [15:0] P_COL_BODY  = COL_BODY,
   parameter logic [15:0] P_COL_HEAD  = COL_HEAD,
   parameter logic [15:0] P_COL_FOOD  = COL_FOOD,
   parameter logic [15:0] P_COL_GRID  = COL_GRID,
   parameter bit          GRID_LINES  = 1'b1,
   parameter int unsigned BLINK_BIT   = 4
) (
   input  logic        clk_disp,
   input  logic        rst,
   input  logic [9:0]  x_pos,
   input  logic [9:0]  y_pos,
   input  logic        inrange,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   input  logic        wr_en,
   input  logic [4:0]  wr_row,
   input  logic [4:0]  wr_col,
   input  logic [1:0]  wr_data,
   input  logic [4:0]  rd_row,
   input  logic [4:0]  rd_col,
   output logic [1:0]  rd_data,
   output logic [15:0] rgb,
   output logic        h_sync_out,
   output logic        v_sync_out,
   output logic        frame_start
);

   logic [4:0]  col, row;
   logic        v0_d, e0_d;
   logic        v0, e0, hs0, vs0;
   logic [1:0]  cell0;
   logic [15:0] rgb_d;
   logic        vs_prev;
   logic        vs_rise;
   logic [5:0]  frame_cnt;

   assign col  = x_pos[8:4];
   assign row  = y_pos[8:4];
   assign v0_d = inrange & ~x_pos[9] & ~y_pos[9] & in_grid(row, col);
   assign e0_d = (x_pos[3:0] == 4'd0) | (y_pos[3:0] == 4'd0);

   snake_grid_ram u_ram (
      .clk_disp     (clk_disp),
      .rst          (rst),
      .we           (wr_en & in_grid(wr_row, wr_col)),
      .wr_addr      ({wr_row, wr_col}),
      .wr_data      (wr_data),
      .pix_addr     ({row, col}),
      .pix_data     (cell0),
      .game_addr    ({rd_row, rd_col}),
      .game_in_grid (in_grid(rd_row, rd_col)),
      .game_data    (rd_data)
   );

   // S1 colour select; the S0 cell read comes straight from the RAM register.
   always_comb begin
      rgb_d = 16'h0000;
      if (v0) begin
         unique case (cell_t'(cell0))
            CELL_EMPTY: rgb_d = (GRID_LINES && e0) ? P_COL_GRID : P_COL_EMPTY;
            CELL_BODY:  rgb_d = P_COL_BODY;
            CELL_HEAD:  rgb_d = P_COL_HEAD;
            CELL_FOOD:  rgb_d = frame_cnt[BLINK_BIT] ? P_COL_EMPTY : P_COL_FOOD;
         endcase
      end
   end

   // NOTE: all state below uses non-blocking assignments so every stage
   // samples the previous cycle's values regardless of statement order.
   always_ff @(posedge clk_disp or negedge rst) begin
      if (!rst) begin
         v0         <= 1'b0;
         e0         <= 1'b0;
         hs0        <= 1'b0;
         vs0        <= 1'b0;
         rgb        <= 16'h0000;
         h_sync_out <= 1'b1;
         v_sync_out <= 1'b0;
      end else begin
         v0         <= v0_d;
         e0         <= e0_d;
         hs0        <= h_sync_in;
         vs0        <= v_sync_in;
         rgb        <= rgb_d;
         h_sync_out <= hs0;
         v_sync_out <= vs0;
      end
   end

   assign vs_rise = v_sync_in & ~vs_prev;

   always_ff @(posedge clk_disp or negedge rst) begin
      if (!rst) begin
         vs_prev     <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 6'd0;
      end else begin
         vs_prev     <= v_sync_in;
         frame_start <= vs_rise;
         if (vs_rise) frame_cnt <= frame_cnt + 6'd1;
      end
   end

endmodule
